// File: rtl/alu_mdu_pkg.sv
// Shared opcodes, FSM states and opcode-decoding helpers for the ALU with
// its iterative multiply/divide unit.
package alu_mdu_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'h00,
    OP_SUB   = 5'h01,
    OP_SLT   = 5'h02,
    OP_SLTU  = 5'h03,
    OP_AND   = 5'h04,
    OP_OR    = 5'h05,
    OP_NOR   = 5'h06,
    OP_XOR   = 5'h07,
    OP_SLL   = 5'h08,
    OP_SRL   = 5'h09,
    OP_SRA   = 5'h0A,
    OP_ASS   = 5'h0B,
    OP_MUL   = 5'h10,
    OP_MULH  = 5'h11,
    OP_MULHU = 5'h12,
    OP_DIV   = 5'h13,
    OP_MOD   = 5'h14,
    OP_DIVU  = 5'h15,
    OP_MODU  = 5'h16
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_MODU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_MODU);
  endfunction

  function automatic logic is_signed(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  function automatic logic wants_high_or_rem(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_MULHU) || (op == OP_MOD) || (op == OP_MODU);
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response handshake bundle between the execute stage and alu_mdu.
interface alu_mdu_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] src0;
  logic [WIDTH-1:0] src1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;

  modport master (output in_valid, op, src0, src1, out_ready,
                  input  in_ready, out_valid, res);
  modport slave  (input  in_valid, op, src0, src1, out_ready,
                  output in_ready, out_valid, res);
endinterface

// File: rtl/alu_mdu_iter.sv
// Radix-2 multiply/divide datapath: latches magnitudes on start, runs WIDTH
// steps, then presents the sign-corrected result while done is high.
// op/a/b must stay stable from start until done (the caller holds them).
module mdu_iter
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             last,
  output logic             done,
  output logic [WIDTH-1:0] res
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] acc_r, mul_next_s, div_next_s, prod_s;
  logic [WIDTH-1:0]   opd_r, a_mag_s, b_mag_s, quot_s, rem_s;
  logic [WIDTH:0]     mul_sum_s, div_diff_s;
  logic [CW-1:0]      count_r;
  logic               fix_r, neg_r, rem_neg_r, dz_r, ovf_r, a_neg_s, b_neg_s;

  // operand magnitudes and one step of shift-add / restoring shift-subtract
  always_comb begin
    a_neg_s    = is_signed(op) && a[WIDTH-1];
    b_neg_s    = is_signed(op) && b[WIDTH-1];
    a_mag_s    = a_neg_s ? -a : a;
    b_mag_s    = b_neg_s ? -b : b;
    mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
    mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    div_diff_s = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, opd_r};
    div_next_s = div_diff_s[WIDTH] ? {acc_r[2*WIDTH-2:0], 1'b0}
                                   : {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
  end

  // sign correction, divide-by-zero / overflow overrides, half selection
  always_comb begin
    prod_s = neg_r ? -acc_r : acc_r;
    quot_s = neg_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    rem_s  = rem_neg_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
    if (ovf_r) begin
      quot_s = MIN;
      rem_s  = {WIDTH{1'b0}};
    end else if (dz_r) begin
      quot_s = {WIDTH{1'b1}};
      rem_s  = a;
    end else begin
      quot_s = quot_s;
      rem_s  = rem_s;
    end
    if (is_div(op)) begin
      res = wants_high_or_rem(op) ? rem_s : quot_s;
    end else begin
      res = wants_high_or_rem(op) ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
    end
  end

  // accumulator, step counter and latched sign/override flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r     <= {(2*WIDTH){1'b0}};
      opd_r     <= {WIDTH{1'b0}};
      count_r   <= {CW{1'b0}};
      fix_r     <= 1'b0;
      neg_r     <= 1'b0;
      rem_neg_r <= 1'b0;
      dz_r      <= 1'b0;
      ovf_r     <= 1'b0;
    end else if (flush) begin
      count_r <= {CW{1'b0}};
      fix_r   <= 1'b0;
    end else if (start) begin
      acc_r     <= {{WIDTH{1'b0}}, a_mag_s};
      opd_r     <= b_mag_s;
      count_r   <= CW'(WIDTH);
      fix_r     <= 1'b0;
      neg_r     <= (a_neg_s ^ b_neg_s) && !(is_div(op) && (b == {WIDTH{1'b0}}));
      rem_neg_r <= a_neg_s;
      dz_r      <= is_div(op) && (b == {WIDTH{1'b0}});
      ovf_r     <= is_div(op) && is_signed(op) && (a == MIN) && (b == {WIDTH{1'b1}});
    end else if (count_r != {CW{1'b0}}) begin
      acc_r   <= is_div(op) ? div_next_s : mul_next_s;
      count_r <= count_r - CW'(1);
      fix_r   <= (count_r == CW'(1));
    end else begin
      fix_r <= 1'b0;
    end
  end

  assign busy = (count_r != {CW{1'b0}}) || fix_r;
  assign last = (count_r == CW'(1));
  assign done = fix_r;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: single-cycle base ops plus iterative mul/div behind a
// valid/ready handshake with a registered, held result.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  alu_mdu_if.slave bus
);
  state_e           state_r, state_nx;
  logic [4:0]       op_r;
  logic [WIDTH-1:0] src0_r, src1_r, res_r, base_res_s, mdu_res_s;
  logic [SHW-1:0]   shamt_s;
  logic             accept_s, mdu_busy_s, mdu_last_s, mdu_done_s;

  assign bus.in_ready  = !flush && ((state_r == IDLE) || ((state_r == DONE) && bus.out_ready));
  assign accept_s      = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_r == DONE);
  assign bus.res       = res_r;

  // single-cycle base operations; unknown and mul/div codes yield zero
  always_comb begin
    shamt_s    = bus.src1[SHW-1:0];
    base_res_s = {WIDTH{1'b0}};
    case (bus.op)
      OP_ADD:  base_res_s = bus.src0 + bus.src1;
      OP_SUB:  base_res_s = bus.src0 - bus.src1;
      OP_SLT:  base_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.src0) < $signed(bus.src1))};
      OP_SLTU: base_res_s = {{(WIDTH-1){1'b0}}, (bus.src0 < bus.src1)};
      OP_AND:  base_res_s = bus.src0 & bus.src1;
      OP_OR:   base_res_s = bus.src0 | bus.src1;
      OP_NOR:  base_res_s = ~(bus.src0 | bus.src1);
      OP_XOR:  base_res_s = bus.src0 ^ bus.src1;
      OP_SLL:  base_res_s = bus.src0 << shamt_s;
      OP_SRL:  base_res_s = bus.src0 >> shamt_s;
      OP_SRA:  base_res_s = $signed(bus.src0) >>> shamt_s;
      OP_ASS:  base_res_s = bus.src1;
      default: base_res_s = {WIDTH{1'b0}};
    endcase
  end

  // next-state logic; flush wins over everything
  always_comb begin
    state_nx = state_r;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) state_nx = is_muldiv(bus.op) ? PREP : DONE;
          else          state_nx = IDLE;
        end
        PREP: state_nx = CALC;
        CALC: begin
          if (mdu_last_s)       state_nx = FIX;
          else if (!mdu_busy_s) state_nx = IDLE;
          else                  state_nx = CALC;
        end
        FIX: begin
          if (mdu_done_s) state_nx = DONE;
          else            state_nx = IDLE;
        end
        DONE: begin
          if (!bus.out_ready)  state_nx = DONE;
          else if (accept_s)   state_nx = is_muldiv(bus.op) ? PREP : DONE;
          else                 state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx;
  end

  // operands are captured only on acceptance; result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r   <= 5'h00;
      src0_r <= {WIDTH{1'b0}};
      src1_r <= {WIDTH{1'b0}};
      res_r  <= {WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        op_r   <= bus.op;
        src0_r <= bus.src0;
        src1_r <= bus.src1;
      end else begin
        op_r   <= op_r;
        src0_r <= src0_r;
        src1_r <= src1_r;
      end
      if (accept_s && !is_muldiv(bus.op))                 res_r <= base_res_s;
      else if ((state_r == FIX) && mdu_done_s && !flush) res_r <= mdu_res_s;
      else                                                res_r <= res_r;
    end
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .start (state_r == PREP),
    .op    (op_r),
    .a     (src0_r),
    .b     (src1_r),
    .busy  (mdu_busy_s),
    .last  (mdu_last_s),
    .done  (mdu_done_s),
    .res   (mdu_res_s)
  );

endmodule
